// File: rtl/spectrum_pkg.sv
// rtl/spectrum_pkg.sv - shared constants, scan state and read-port owner encodings
package spectrum_pkg;

    localparam int BANDS        = 32;
    localparam int DATA_WIDTH   = 16;
    localparam int HEIGHT_WIDTH = 6;
    localparam int SHIFT        = 10;
    localparam int IDX_WIDTH    = $clog2(BANDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } scan_state_t;

    // Who issued the read currently in flight on the band buffer port.
    typedef enum logic {
        SCAN = 1'b0,
        HOST = 1'b1
    } owner_t;

    function automatic logic is_last_band(input logic [IDX_WIDTH-1:0] idx);
        return idx == IDX_WIDTH'(BANDS - 1);
    endfunction

endpackage

// File: rtl/band_scan_ctrl_if.sv
// rtl/band_scan_ctrl_if.sv - buffer read port, host port, bar stream and status bundle
interface band_scan_ctrl_if;
    import spectrum_pkg::*;

    logic                    frame_stb;

    logic [IDX_WIDTH-1:0]    buf_rd_addr;
    logic                    buf_rd_en;
    logic [DATA_WIDTH-1:0]   buf_rd_data;
    logic                    buf_rd_data_valid;

    logic                    host_req;
    logic [IDX_WIDTH-1:0]    host_addr;
    logic                    host_gnt;
    logic [DATA_WIDTH-1:0]   host_data;
    logic                    host_data_valid;

    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [HEIGHT_WIDTH-1:0] m_axis_tdata;
    logic [IDX_WIDTH-1:0]    m_axis_tuser;
    logic                    m_axis_tlast;

    logic                    busy;
    logic                    frame_drop;

    // Controller side.
    modport master (
        input  frame_stb,
        output buf_rd_addr, buf_rd_en,
        input  buf_rd_data, buf_rd_data_valid,
        input  host_req, host_addr,
        output host_gnt, host_data, host_data_valid,
        output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
        input  m_axis_tready,
        output busy, frame_drop
    );

    // Buffer, host and renderer side.
    modport slave (
        output frame_stb,
        input  buf_rd_addr, buf_rd_en,
        output buf_rd_data, buf_rd_data_valid,
        output host_req, host_addr,
        input  host_gnt, host_data, host_data_valid,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
        output m_axis_tready,
        input  busy, frame_drop
    );

endinterface

// File: rtl/band_height_sat.sv
// rtl/band_height_sat.sv - combinational magnitude shift and bar height saturation
module band_height_sat #(
    parameter int DATA_WIDTH   = 16,
    parameter int HEIGHT_WIDTH = 6,
    parameter int SHIFT        = 10
) (
    input  logic [DATA_WIDTH-1:0]   i_mag,
    output logic [HEIGHT_WIDTH-1:0] o_height
);

    // Tallest bar the renderer can draw, widened for the compare.
    localparam logic [DATA_WIDTH-1:0] HMAX = DATA_WIDTH'((1 << HEIGHT_WIDTH) - 1);

    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_mag >> SHIFT;

    // Anything above the tallest bar clips to full height instead of wrapping.
    assign o_height  = (w_shifted > HMAX) ? {HEIGHT_WIDTH{1'b1}}
                                          : w_shifted[HEIGHT_WIDTH-1:0];

endmodule

// File: rtl/band_scan_ctrl.sv
// rtl/band_scan_ctrl.sv - per-frame band readout sequencer with shared read port and bar stream
module band_scan_ctrl
    import spectrum_pkg::*;
(
    input  logic             clk_50m,
    input  logic             rst_n,
    band_scan_ctrl_if.master bus
);

    scan_state_t             r_state;
    scan_state_t             w_state_nxt;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic                    r_pending;
    owner_t                  r_owner;
    logic [HEIGHT_WIDTH-1:0] r_tdata;
    logic [DATA_WIDTH-1:0]   r_host_data;

    logic                    w_start;
    logic                    w_last;
    logic                    w_hs;
    logic                    w_scan_rtn;
    logic                    w_host_rtn;
    logic [HEIGHT_WIDTH-1:0] w_height;

    logic                    w_port_free;
    logic                    w_host_gnt;
    logic                    w_rd_en;
    logic [IDX_WIDTH-1:0]    w_rd_addr;
    logic                    w_tvalid;
    logic [IDX_WIDTH-1:0]    w_tuser;
    logic                    w_tlast;
    logic                    w_busy;
    logic                    w_frame_drop;

    // A frame is due either from a strobe now or one remembered during the last scan.
    assign w_start    = r_pending | bus.frame_stb;
    assign w_last     = is_last_band(r_idx);
    assign w_hs       = (r_state == SEND) & bus.m_axis_tready;

    // Returns are steered by the owner latched when that read was issued.
    assign w_scan_rtn = bus.buf_rd_data_valid & (r_owner == SCAN);
    assign w_host_rtn = bus.buf_rd_data_valid & (r_owner == HOST);

    band_height_sat #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HEIGHT_WIDTH(HEIGHT_WIDTH),
        .SHIFT       (SHIFT)
    ) u_sat (
        .i_mag   (bus.buf_rd_data),
        .o_height(w_height)
    );

    // State register.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: one read, one wait for data, one beat per band.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start)    w_state_nxt = READ;
            READ:                 w_state_nxt = WAIT;
            WAIT: if (w_scan_rtn) w_state_nxt = SEND;
            SEND: if (w_hs)       w_state_nxt = w_last ? IDLE : READ;
            default:              w_state_nxt = IDLE;
        endcase
    end

    // Output decode: read-port arbitration, stream beat and status.
    always_comb begin
        // The scan owns the port only in READ; an imminent scan start also blocks
        // the host. Holding reset closes the port so every output reads 0 in reset.
        w_port_free  = rst_n & ((r_state == WAIT) | (r_state == SEND) |
                                ((r_state == IDLE) & ~w_start));
        w_host_gnt   = w_port_free & bus.host_req;
        w_rd_en      = (r_state == READ) | w_host_gnt;
        w_rd_addr    = '0;
        if (r_state == READ) begin
            w_rd_addr = r_idx;
        end else if (w_host_gnt) begin
            w_rd_addr = bus.host_addr;
        end
        w_tvalid     = (r_state == SEND);
        w_tuser      = w_tvalid ? r_idx : '0;
        w_tlast      = w_tvalid & w_last;
        w_busy       = (r_state != IDLE);
        w_frame_drop = w_busy & bus.frame_stb & r_pending;
    end

    // Band index: restarts with each frame, advances on every accepted beat.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if ((r_state == IDLE) && w_start) begin
            r_idx <= '0;
        end else if (w_hs) begin
            r_idx <= w_last ? '0 : r_idx + IDX_WIDTH'(1);
        end
    end

    // Remember one strobe that arrives mid-scan; further strobes are reported as drops.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if ((r_state == IDLE) && w_start) begin
            r_pending <= 1'b0;
        end else if (w_busy && bus.frame_stb) begin
            r_pending <= 1'b1;
        end
    end

    // Tag the read being issued this cycle so its data can be routed next cycle.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= SCAN;
        end else if (r_state == READ) begin
            r_owner <= SCAN;
        end else if (w_host_gnt) begin
            r_owner <= HOST;
        end
    end

    // Stream holding register: loaded once per band, stable through backpressure.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata <= '0;
        end else if ((r_state == WAIT) && w_scan_rtn) begin
            r_tdata <= w_height;
        end
    end

    // Last host result, held until the next host read returns.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_host_data <= '0;
        end else if (w_host_rtn) begin
            r_host_data <= bus.buf_rd_data;
        end
    end

    assign bus.buf_rd_en       = w_rd_en;
    assign bus.buf_rd_addr     = w_rd_addr;
    assign bus.host_gnt        = w_host_gnt;
    assign bus.host_data_valid = w_host_rtn;
    assign bus.host_data       = w_host_rtn ? bus.buf_rd_data : r_host_data;
    assign bus.m_axis_tvalid   = w_tvalid;
    assign bus.m_axis_tdata    = r_tdata;
    assign bus.m_axis_tuser    = w_tuser;
    assign bus.m_axis_tlast    = w_tlast;
    assign bus.busy            = w_busy;
    assign bus.frame_drop      = w_frame_drop;

endmodule

// File: tb/tb_band_scan_ctrl.sv
// tb/tb_band_scan_ctrl.sv - self-checking bench for band_scan_ctrl
module tb_band_scan_ctrl;
    import spectrum_pkg::*;

    localparam int LIMIT = 3000;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk_50m = ~clk_50m;

    band_scan_ctrl_if bus ();

    band_scan_ctrl dut (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [HEIGHT_WIDTH-1:0] tdata;
        logic [IDX_WIDTH-1:0]    tuser;
        logic                    tlast;
    } beat_t;

    int checks = 0;
    int errors = 0;

    logic [DATA_WIDTH-1:0]   mem [BANDS];
    logic [HEIGHT_WIDTH-1:0] beat_log [BANDS];

    beat_t                q[$];
    bit                   m_busy;
    bit                   m_pending;
    int                   m_scan_next;
    bit                   m_gnt_prev;
    logic [IDX_WIDTH-1:0] m_gnt_addr_prev;

    int                    hs_count;
    int                    frames_done;
    int                    drop_seen;
    int                    gnt_count;
    logic [DATA_WIDTH-1:0] last_host_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bar_of(input int mag);
        int h;
        h = mag / (1 << SHIFT);
        return (h > (1 << HEIGHT_WIDTH) - 1) ? (1 << HEIGHT_WIDTH) - 1 : h;
    endfunction

    // Band buffer: one-cycle read latency.
    always @(posedge clk_50m) begin
        bus.buf_rd_data_valid <= bus.buf_rd_en;
        if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];
    end

    // Frame-level model and per-cycle compare.
    always @(negedge clk_50m) begin
        bit    start_now;
        bit    end_now;
        bit    hs;
        beat_t b;
        if (!rst_n) begin
            q.delete();
            m_busy      = 1'b0;
            m_pending   = 1'b0;
            m_scan_next = 0;
            m_gnt_prev  = 1'b0;
        end else begin
            start_now = !m_busy && (bus.frame_stb || m_pending);
            hs        = bus.m_axis_tvalid && bus.m_axis_tready;
            end_now   = 1'b0;

            chk("busy", bus.busy, m_busy);
            chk("frame_drop", bus.frame_drop, bus.frame_stb & m_busy & m_pending);
            chk("host_data_valid", bus.host_data_valid, m_gnt_prev);
            if (bus.host_data_valid) begin
                chk("host_data", bus.host_data, mem[m_gnt_addr_prev]);
                last_host_data = bus.host_data;
            end
            if (bus.host_gnt) begin
                gnt_count++;
                chk("host_gnt_req", bus.host_req, 1);
                chk("host_rd_en", bus.buf_rd_en, 1);
                chk("host_rd_addr", bus.buf_rd_addr, bus.host_addr);
                chk("host_gnt_at_scan_start", start_now, 0);
            end else if (bus.buf_rd_en) begin
                chk("scan_rd_in_frame", m_busy, 1);
                chk("scan_rd_addr", bus.buf_rd_addr, m_scan_next);
                m_scan_next++;
            end
            if (bus.m_axis_tvalid) begin
                if (q.size() == 0) begin
                    chk("tvalid_without_beat", 1, 0);
                end else begin
                    chk("tdata", bus.m_axis_tdata, q[0].tdata);
                    chk("tuser", bus.m_axis_tuser, q[0].tuser);
                    chk("tlast", bus.m_axis_tlast, q[0].tlast);
                    if (hs) begin
                        b = q.pop_front();
                        hs_count++;
                        beat_log[b.tuser] = bus.m_axis_tdata;
                        if (b.tlast) begin
                            frames_done++;
                            end_now = 1'b1;
                        end
                    end
                end
            end
            if (bus.frame_drop) drop_seen++;

            if (start_now) begin
                for (int k = 0; k < BANDS; k++) begin
                    b.tdata = HEIGHT_WIDTH'(bar_of(int'(mem[k])));
                    b.tuser = IDX_WIDTH'(k);
                    b.tlast = (k == BANDS - 1);
                    q.push_back(b);
                end
                m_busy      = 1'b1;
                m_pending   = 1'b0;
                m_scan_next = 0;
            end else if (m_busy && bus.frame_stb) begin
                m_pending = 1'b1;
            end
            if (end_now) m_busy = 1'b0;

            m_gnt_prev      = bus.host_gnt;
            m_gnt_addr_prev = bus.host_addr;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_buf_rd_en"},       bus.buf_rd_en, 0);
        chk({tag, "_buf_rd_addr"},     bus.buf_rd_addr, 0);
        chk({tag, "_host_gnt"},        bus.host_gnt, 0);
        chk({tag, "_host_data"},       bus.host_data, 0);
        chk({tag, "_host_data_valid"}, bus.host_data_valid, 0);
        chk({tag, "_tvalid"},          bus.m_axis_tvalid, 0);
        chk({tag, "_tdata"},           bus.m_axis_tdata, 0);
        chk({tag, "_tuser"},           bus.m_axis_tuser, 0);
        chk({tag, "_tlast"},           bus.m_axis_tlast, 0);
        chk({tag, "_busy"},            bus.busy, 0);
        chk({tag, "_frame_drop"},      bus.frame_drop, 0);
    endtask

    // One strobe, run until idle; returns cycles to first tvalid and to busy low.
    task automatic scan_frame(input bit rand_ready, output int lat, output int dur);
        int n;
        bus.frame_stb     = 1'b1;
        bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk_50m); #1;
        bus.frame_stb = 1'b0;
        n   = 1;
        lat = -1;
        while (n < LIMIT) begin
            if (lat < 0 && bus.m_axis_tvalid) lat = n;
            if (lat >= 0 && !bus.busy) break;
            if (rand_ready) bus.m_axis_tready = 1'($urandom_range(0, 1));
            @(posedge clk_50m); #1;
            n++;
        end
        dur = n;
        chk("frame_timeout", (n < LIMIT), 1);
        bus.m_axis_tready = 1'b1;
    endtask

    initial begin
        int lat, dur, h0, f0, d0, g0, idle_cnt, n;
        bit found;

        bus.frame_stb     = 1'b0;
        bus.host_req      = 1'b0;
        bus.host_addr     = '0;
        bus.m_axis_tready = 1'b0;
        for (int k = 0; k < BANDS; k++) mem[k] = DATA_WIDTH'(k * 1024);

        rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        check_all_zero("reset");
        @(posedge clk_50m); #1;
        rst_n = 1'b1;
        @(posedge clk_50m); #1;

        // Plain frame readout: band k holds k*1024, so bar k is k.
        h0 = hs_count; f0 = frames_done;
        scan_frame(1'b0, lat, dur);
        chk("first_tvalid_latency", lat, 3);
        chk("frame_cycles", dur, 97);
        chk("frame_beats", hs_count - h0, 32);
        chk("frame_count", frames_done - f0, 1);
        for (int k = 0; k < BANDS; k++) chk("bar_k", beat_log[k], k);

        // Saturation boundaries.
        mem[0]  = 16'hFFFF;
        mem[1]  = 16'h03FF;
        mem[2]  = 16'h0400;
        mem[31] = 16'h8000;
        @(posedge clk_50m); #1;
        scan_frame(1'b0, lat, dur);
        chk("sat_ffff", beat_log[0], 63);
        chk("sat_03ff", beat_log[1], 0);
        chk("sat_0400", beat_log[2], 1);
        chk("sat_8000", beat_log[31], 32);

        // Random backpressure.
        h0 = hs_count; f0 = frames_done;
        scan_frame(1'b1, lat, dur);
        chk("bp_beats", hs_count - h0, 32);
        chk("bp_frames", frames_done - f0, 1);

        // Host contention during a scan.
        mem[5] = 16'h1234;
        bus.host_addr = 5'd5;
        bus.host_req  = 1'b1;
        g0 = gnt_count; h0 = hs_count;
        scan_frame(1'b0, lat, dur);
        chk("host_first_tvalid_latency", lat, 3);
        chk("host_frame_cycles", dur, 97);
        chk("host_frame_beats", hs_count - h0, 32);
        bus.host_req = 1'b0;
        repeat (2) @(posedge clk_50m);
        #1;
        chk("host_granted", (gnt_count > g0 + 10), 1);
        chk("host_band5", last_host_data, 16'h1234);

        // Frame overrun: strobes at cycles 0, 10 and 20 of one scan.
        f0 = frames_done; d0 = drop_seen; h0 = hs_count;
        idle_cnt = 0;
        n = 0;
        while (n < LIMIT) begin
            bus.frame_stb = (n == 0 || n == 10 || n == 20);
            @(posedge clk_50m); #1;
            bus.frame_stb = 1'b0;
            idle_cnt = bus.busy ? 0 : idle_cnt + 1;
            n++;
            if (n > 25 && idle_cnt >= 2) break;
        end
        chk("overrun_timeout", (n < LIMIT), 1);
        chk("overrun_frames", frames_done - f0, 2);
        chk("overrun_drops", drop_seen - d0, 1);
        chk("overrun_beats", hs_count - h0, 64);

        // Reset asserted while band 12 is waiting for the sink.
        bus.frame_stb = 1'b1;
        @(posedge clk_50m); #1;
        bus.frame_stb = 1'b0;
        found = 1'b0;
        n = 0;
        while (n < LIMIT) begin
            if (bus.m_axis_tvalid && bus.m_axis_tuser == 5'd12) begin
                bus.m_axis_tready = 1'b0;
                found = 1'b1;
                break;
            end
            @(posedge clk_50m); #1;
            n++;
        end
        chk("reached_band12", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midscan_reset");
        repeat (2) @(posedge clk_50m);
        #1;
        rst_n = 1'b1;
        bus.m_axis_tready = 1'b1;
        bus.host_addr = 5'd3;
        bus.host_req  = 1'b1;
        #1;
        chk("post_reset_host_gnt", bus.host_gnt, 1);
        @(posedge clk_50m); #1;
        bus.host_req = 1'b0;
        @(posedge clk_50m); #1;
        chk("post_reset_host_data", last_host_data, 16'h0C00);
        h0 = hs_count;
        repeat (5) @(posedge clk_50m);
        #1;
        chk("post_reset_no_beats", hs_count - h0, 0);
        chk("post_reset_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/band_scan_ctrl.md
Name: band_scan_ctrl

Overview:
Sequences readout of the spectrum band buffer once per FFT frame and shares its single read port with a host/debug requester. On each frame strobe it reads bands 0..BANDS-1 and converts each magnitude to a saturated bar height. It emits the heights as an AXI-Stream frame to the bar renderer, with full backpressure. The block sits between the band buffer's read port and the display path.

Parameters:
BANDS, 32, number of bands per frame (power of two, >=2)
DATA_WIDTH, 16, band magnitude width
HEIGHT_WIDTH, 6, bar height width
SHIFT, 10, right-shift applied to the magnitude before saturation

Ports:
clk_50m  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_stb  in  1  one-cycle pulse from the band buffer: a new frame has been written
buf_rd_addr  out  $clog2(BANDS)  band buffer read address
buf_rd_en  out  1  band buffer read enable
buf_rd_data  in  DATA_WIDTH  band buffer read data; valid 1 cycle after buf_rd_en
buf_rd_data_valid  in  1  band buffer read-data valid
host_req  in  1  host read request; held until granted
host_addr  in  $clog2(BANDS)  host band address
host_gnt  out  1  one-cycle pulse: the host read was issued this cycle
host_data  out  DATA_WIDTH  host read result
host_data_valid  out  1  one-cycle pulse, 1 cycle after host_gnt
m_axis_tvalid  out  1  bar stream valid
m_axis_tready  in  1  bar stream ready
m_axis_tdata  out  HEIGHT_WIDTH  bar height
m_axis_tuser  out  $clog2(BANDS)  band index of the current beat
m_axis_tlast  out  1  asserted on band BANDS-1
busy  out  1  scan in progress (state != IDLE)
frame_drop  out  1  one-cycle pulse: a frame strobe was lost

Behaviour:
- Reset (async, rst_n=0): state=IDLE, band index=0, pending=0, owner=0. All outputs are 0.
- FSM states and transitions:
  - IDLE: if pending or frame_stb, go to READ with idx=0 and clear pending.
  - READ: drive buf_rd_en=1 and buf_rd_addr=idx for exactly 1 cycle, set owner=SCAN, go to WAIT.
  - WAIT: on buf_rd_data_valid, load the output register, go to SEND.
  - SEND: drive m_axis_tvalid=1 and hold tdata/tuser/tlast stable until tready. On the handshake: if idx==BANDS-1, go to IDLE with idx=0; else increment idx and go to READ.
- Height calculation: h = buf_rd_data >> SHIFT. If h > 2^HEIGHT_WIDTH-1, tdata = 2^HEIGHT_WIDTH-1; else tdata = h[HEIGHT_WIDTH-1:0].
- Latency: frame_stb in IDLE gives READ in the next cycle. The first tvalid appears 3 cycles after frame_stb. A full frame takes at least 3*BANDS cycles with tready held high.
- Host arbitration:
  - The port is free in IDLE, WAIT and SEND (no scan read is issued in those states). The scan has absolute priority in READ.
  - When the port is free and host_req=1: buf_rd_en=1, buf_rd_addr=host_addr, host_gnt=1, owner=HOST.
  - Exception: in IDLE with (pending | frame_stb) the scan starts instead and the host waits.
  - A host read issued in WAIT cannot collide with scan data, because the scan read was issued in the previous cycle.
- Return routing: each buf_rd_data_valid is steered by the owner value latched when that read was issued, tracked by a 1-deep tag pipeline. For HOST, host_data=buf_rd_data and host_data_valid=1; host_data holds its value until the next host read. A HOST return never touches the stream register.
- Frame strobes during a scan:
  - frame_stb while busy sets pending.
  - frame_stb while pending is already 1 pulses frame_drop; pending stays 1.
  - frame_stb in the same cycle as the final handshake sets pending.
- buf_rd_data_valid outside WAIT with owner=SCAN cannot occur by construction; it is ignored.
- Reset asserted mid-scan aborts immediately. No partial tlast is emitted after reset.

Decomposition:
- Shared package (spectrum_pkg): BANDS, DATA_WIDTH, HEIGHT_WIDTH, the state encoding (IDLE, READ, WAIT, SEND) and the owner encoding (SCAN, HOST).
- One natural sub-module: band_height_sat, a combinational shift-and-saturate unit, reused later by the peak-hold display path.

Test Plan:
- Frame readout: buffer preloaded with band k = k*1024, tready=1, pulse frame_stb -> 32 beats with tdata=k (saturated to 63 where k*1024>>10 > 63), tuser=k, tlast only on beat 31, busy low afterwards.
- Saturation: buffer value 0xFFFF -> tdata=63. Value 0x03FF -> tdata=0. Value 0x0400 -> tdata=1.
- Backpressure: tready toggled with a random 50% duty -> no beat lost or duplicated, and tdata/tuser stay stable while tvalid=1 and tready=0.
- Host contention: host_req=1 with host_addr=5 held throughout a scan -> host_gnt occurs only in WAIT or SEND, host_data equals the band 5 value, and the stream sequence is unaffected.
- Frame overrun: frame_stb at cycle 10 and cycle 20 of a scan -> after the current frame ends, exactly one further frame is scanned; one frame_drop pulse at cycle 20.
- Async reset: rst_n asserted during SEND of band 12 -> all outputs 0 immediately. After release, an idle host_req is granted within 1 cycle.
